mem_port_arbiter: RTL and testbench

- Shares the single unified memory port of the multicycle RISC-V core between two requesters: instruction fetch (IF) and data load/store (D).
- Replaces the direct memory hookup. Requesters use a level req / one-cycle ready handshake. The memory side has variable latency and acknowledges with mem_ack.
- Ties are arbitrated round-robin. A timeout watchdog completes any transaction the memory never acknowledges and flags it with an error.

---
 rtl/mem_port_arbiter_pkg.sv | 26 ++
 rtl/arb_timeout_counter.sv | 27 ++
 rtl/mem_port_arbiter.sv | 130 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 411 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings for the memory port arbiter: FSM states, grant identities
// and the default acknowledge timeout.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_BUSY = 2'd1,
    ARB_RESP = 2'd2
  } arb_state_t;

  typedef enum logic {
    GRANT_IF = 1'b0,
    GRANT_D  = 1'b1
  } grant_t;

  localparam int DEFAULT_TIMEOUT = 16;

  // Round-robin pick: a tie goes to whoever was not served last.
  function automatic grant_t pick_grant(input logic fetch_req, input logic data_req,
                                        input grant_t last);
    if (fetch_req && data_req) return (last == GRANT_IF) ? GRANT_D : GRANT_IF;
    else if (data_req)         return GRANT_D;
    else                       return GRANT_IF;
  endfunction

endpackage

// File: rtl/arb_timeout_counter.sv
// Clear/enable up-counter that flags when it holds TIMEOUT-1, the last BUSY
// cycle the arbiter will wait for mem_ack.
module arb_timeout_counter #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic terminal
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [CNT_W-1:0] count;

  // NOTE: sequential state is written with <= so every flop samples the
  // pre-edge values of its neighbours, independent of process ordering.
  always_ff @(posedge clk) begin
    if (!reset)      count <= '0;
    else if (clear)  count <= '0;
    else if (enable) count <= count + CNT_W'(1);
  end

  assign terminal = (count == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the unified memory port between instruction fetch and data access
// with round-robin tie-breaking and a watchdog for unacknowledged requests.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ready,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_err,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ready,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_err,
  output logic              mem_valid,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack
);

  arb_state_t        state, state_next;
  grant_t            last_grant, grant_sel;
  logic              grant_load, ack_take, timeout_take;
  logic              cnt_clear, cnt_enable, cnt_terminal;
  logic [ADDR_W-1:0] req_addr;
  logic              req_we;
  logic [DATA_W-1:0] req_wdata;
  logic [DATA_W-1:0] resp_data;
  logic              resp_err;

  arb_timeout_counter #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clk      (clk),
    .reset    (reset),
    .clear    (cnt_clear),
    .enable   (cnt_enable),
    .terminal (cnt_terminal)
  );

  always_ff @(posedge clk) begin
    if (!reset) state <= ARB_IDLE;
    else        state <= state_next;
  end

  // NOTE: every signal driven here gets a default first, so no path through
  // the case leaves one unassigned and no latch is inferred.
  always_comb begin
    state_next   = state;
    grant_sel    = pick_grant(if_req, d_req, last_grant);
    grant_load   = 1'b0;
    ack_take     = 1'b0;
    timeout_take = 1'b0;
    cnt_clear    = 1'b0;
    cnt_enable   = 1'b0;
    unique case (state)
      ARB_IDLE: begin
        if (if_req || d_req) begin
          grant_load = 1'b1;
          cnt_clear  = 1'b1;
          state_next = ARB_BUSY;
        end
      end
      ARB_BUSY: begin
        // An ack on the terminal cycle takes priority over the timeout.
        if (mem_ack) begin
          ack_take   = 1'b1;
          state_next = ARB_RESP;
        end else if (cnt_terminal) begin
          timeout_take = 1'b1;
          state_next   = ARB_RESP;
        end else begin
          cnt_enable = 1'b1;
        end
      end
      ARB_RESP: state_next = ARB_IDLE;
      default:  state_next = ARB_IDLE;
    endcase
  end

  // NOTE: the request/response registers are reset as well as the state so
  // that every output reads 0 while reset is held.
  always_ff @(posedge clk) begin
    if (!reset) begin
      last_grant <= GRANT_IF;
      req_addr   <= '0;
      req_we     <= 1'b0;
      req_wdata  <= '0;
      resp_data  <= '0;
      resp_err   <= 1'b0;
    end else begin
      if (grant_load) begin
        last_grant <= grant_sel;
        req_addr   <= (grant_sel == GRANT_D) ? d_addr : if_addr;
        req_we     <= (grant_sel == GRANT_D) && d_we;
        req_wdata  <= (grant_sel == GRANT_D) ? d_wdata : '0;
      end
      if (ack_take) begin
        resp_data <= mem_rdata;
        resp_err  <= 1'b0;
      end else if (timeout_take) begin
        resp_data <= '0;
        resp_err  <= 1'b1;
      end
    end
  end

  // Outputs decode state and registers only; req inputs never reach mem_*.
  assign mem_valid = (state == ARB_BUSY);
  assign mem_we    = req_we;
  assign mem_addr  = req_addr;
  assign mem_wdata = req_wdata;

  assign if_ready  = (state == ARB_RESP) && (last_grant == GRANT_IF);
  assign d_ready   = (state == ARB_RESP) && (last_grant == GRANT_D);
  assign if_rdata  = resp_data;
  assign d_rdata   = resp_data;
  assign if_err    = if_ready && resp_err;
  assign d_err     = d_ready && resp_err;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: tasks drive requesters and a scripted
// memory, a negedge monitor pops expected responses on every ready pulse.
module tb_mem_port_arbiter;

  typedef struct {
    logic        is_d;
    logic        chk_data;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic        if_ready;
  logic [31:0] if_rdata;
  logic        if_err;
  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic [31:0] d_addr = '0;
  logic [31:0] d_wdata = '0;
  logic        d_ready;
  logic [31:0] d_rdata;
  logic        d_err;
  logic        mem_valid;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic        mem_ack = 1'b0;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  mem_port_arbiter dut (
    .clk       (clk),
    .reset     (reset),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_ready  (if_ready),
    .if_rdata  (if_rdata),
    .if_err    (if_err),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_ready   (d_ready),
    .d_rdata   (d_rdata),
    .d_err     (d_err),
    .mem_valid (mem_valid),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack)
  );

  always #5 clk = ~clk;

  // Response monitor: every ready pulse must match the oldest expectation.
  always @(negedge clk) begin
    exp_t        e;
    logic        got_d;
    logic [31:0] rd;
    logic        er;
    if (if_ready || d_ready) begin
      checks++;
      if (if_ready && d_ready) begin
        errors++;
        $display("FAIL both_ready: if_ready=1 d_ready=1, required only one");
      end else if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_ready: if_ready=%0b d_ready=%0b, required none",
                 if_ready, d_ready);
      end else begin
        e     = sb.pop_front();
        got_d = d_ready;
        rd    = got_d ? d_rdata : if_rdata;
        er    = got_d ? d_err : if_err;
        if (got_d !== e.is_d || er !== e.err || (e.chk_data && rd !== e.rdata)) begin
          errors++;
          $display("FAIL response: got is_d=%0b rdata=%h err=%0b, required is_d=%0b rdata=%h err=%0b",
                   got_d, rd, er, e.is_d, e.rdata, e.err);
        end
      end
    end
  end

  // Requester model: req goes low in the cycle after its ready pulse.
  always begin
    logic di;
    logic dd;
    @(negedge clk);
    if (if_ready || d_ready) begin
      di = if_ready;
      dd = d_ready;
      @(posedge clk);
      #1;
      if (di) if_req = 1'b0;
      if (dd) d_req = 1'b0;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic push_exp(input logic is_d, input logic chk, input logic [31:0] rd,
                          input logic er);
    exp_t e;
    e.is_d = is_d; e.chk_data = chk; e.rdata = rd; e.err = er;
    sb.push_back(e);
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    if_req = 1'b0; d_req = 1'b0; mem_ack = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
  endtask

  // Wait for mem_valid, check the request, ack k cycles after mem_valid rose
  // (k=0: never ack). Returns the number of idle cycles waited.
  task automatic mem_serve(input int k, input logic [31:0] data, input logic [31:0] ea,
                           input logic ewe, input logic [31:0] ewd, input string tag,
                           output int waited);
    waited = 0;
    @(negedge clk);
    while (!mem_valid && waited < 40) begin
      @(negedge clk);
      waited++;
    end
    checks++;
    if (!mem_valid) begin
      errors++;
      $display("FAIL %s_valid: mem_valid=0 after %0d cycles, required 1", tag, waited);
      return;
    end
    checks++;
    if (mem_addr !== ea || mem_we !== ewe || (ewe && mem_wdata !== ewd)) begin
      errors++;
      $display("FAIL %s_req: addr=%h we=%0b wdata=%h, required addr=%h we=%0b wdata=%h",
               tag, mem_addr, mem_we, mem_wdata, ea, ewe, ewd);
    end
    if (k > 0) begin
      repeat (k) @(posedge clk);
      #1 mem_ack = 1'b1;
      mem_rdata = data;
      @(negedge clk);
      checks++;
      if (mem_valid !== 1'b1 || mem_addr !== ea) begin
        errors++;
        $display("FAIL %s_stable: mem_valid=%0b addr=%h at ack, required 1 %h",
                 tag, mem_valid, mem_addr, ea);
      end
      @(posedge clk);
      #1 mem_ack = 1'b0;
      mem_rdata = $urandom;
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    if_req = 1'b1; d_req = 1'b1; mem_ack = 1'b1; if_addr = 32'h55; d_addr = 32'h66;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({mem_valid, mem_we, if_ready, d_ready, if_err, d_err} !== 6'b0) begin
      errors++;
      $display("FAIL reset_ctrl: valid/we/if_rdy/d_rdy/if_err/d_err=%b, required 000000",
               {mem_valid, mem_we, if_ready, d_ready, if_err, d_err});
    end
    checks++;
    if (mem_addr !== '0 || mem_wdata !== '0 || if_rdata !== '0 || d_rdata !== '0) begin
      errors++;
      $display("FAIL reset_data: addr=%h wdata=%h if_rdata=%h d_rdata=%h, required all 0",
               mem_addr, mem_wdata, if_rdata, d_rdata);
    end
    @(posedge clk);
    #1 if_req = 1'b0; d_req = 1'b0; mem_ack = 1'b0;
    @(posedge clk);
    #1 reset = 1'b1;
  endtask

  task automatic test_single_fetch();
    int w;
    @(posedge clk);
    #1 if_addr = 32'h100; if_req = 1'b1;
    @(negedge clk);
    checks++;
    if (mem_valid !== 1'b0) begin
      errors++;
      $display("FAIL fetch_no_comb: mem_valid=%0b in request cycle, required 0", mem_valid);
    end
    push_exp(1'b0, 1'b1, 32'h00500093, 1'b0);
    mem_serve(3, 32'h00500093, 32'h100, 1'b0, 32'h0, "fetch", w);
    checks++;
    if (w != 0) begin
      errors++;
      $display("FAIL fetch_latency: mem_valid after %0d extra cycles, required 0", w);
    end
    @(negedge clk);
    checks++;
    if (if_ready !== 1'b1 || d_ready !== 1'b0) begin
      errors++;
      $display("FAIL fetch_ready: if_ready=%0b d_ready=%0b, required 1 0", if_ready, d_ready);
    end
    @(negedge clk);
    checks++;
    if (if_ready !== 1'b0 || mem_valid !== 1'b0) begin
      errors++;
      $display("FAIL fetch_pulse: if_ready=%0b mem_valid=%0b after pulse, required 0 0",
               if_ready, mem_valid);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_tie_round_robin();
    int w;
    apply_reset();
    @(posedge clk);
    #1 if_addr = 32'h200; d_we = 1'b1; d_addr = 32'h20; d_wdata = 32'hDEADBEEF;
    if_req = 1'b1; d_req = 1'b1;
    push_exp(1'b1, 1'b0, 32'h0, 1'b0);
    push_exp(1'b0, 1'b1, 32'hCAFE0001, 1'b0);
    mem_serve(1, 32'h0, 32'h20, 1'b1, 32'hDEADBEEF, "tie1_d", w);
    mem_serve(2, 32'hCAFE0001, 32'h200, 1'b0, 32'h0, "tie1_if", w);
    checks++;
    if (w != 2) begin
      errors++;
      $display("FAIL tie1_gap: IF started after %0d cycles, required 2", w);
    end
    @(negedge clk);
    checks++;
    if (if_ready !== 1'b1) begin
      errors++;
      $display("FAIL tie1_if_ready: if_ready=%0b, required 1", if_ready);
    end
    repeat (2) @(posedge clk);
    #1 d_we = 1'b0; d_addr = 32'h24; if_req = 1'b1; d_req = 1'b1;
    push_exp(1'b1, 1'b1, 32'h11112222, 1'b0);
    push_exp(1'b0, 1'b1, 32'h33334444, 1'b0);
    mem_serve(1, 32'h11112222, 32'h24, 1'b0, 32'h0, "tie2_d", w);
    mem_serve(1, 32'h33334444, 32'h200, 1'b0, 32'h0, "tie2_if", w);
    repeat (3) @(negedge clk);
  endtask

  task automatic test_timeout();
    int w;
    int n;
    @(posedge clk);
    #1 if_addr = 32'h300; if_req = 1'b1;
    push_exp(1'b0, 1'b1, 32'h0, 1'b1);
    mem_serve(0, 32'h0, 32'h300, 1'b0, 32'h0, "tmo", w);
    n = 1;
    while (n < 40) begin
      @(negedge clk);
      if (!mem_valid) break;
      n++;
    end
    checks++;
    if (n != 16) begin
      errors++;
      $display("FAIL tmo_cycles: mem_valid high %0d cycles, required 16", n);
    end
    checks++;
    if (if_ready !== 1'b1 || if_err !== 1'b1 || if_rdata !== 32'h0) begin
      errors++;
      $display("FAIL tmo_resp: if_ready=%0b if_err=%0b if_rdata=%h, required 1 1 0",
               if_ready, if_err, if_rdata);
    end
    @(negedge clk);
    checks++;
    if (mem_valid !== 1'b0 || if_ready !== 1'b0) begin
      errors++;
      $display("FAIL tmo_idle: mem_valid=%0b if_ready=%0b, required 0 0", mem_valid, if_ready);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_ack_on_timeout();
    int w;
    @(posedge clk);
    #1 if_addr = 32'h400; if_req = 1'b1;
    push_exp(1'b0, 1'b1, 32'h1234, 1'b0);
    mem_serve(15, 32'h1234, 32'h400, 1'b0, 32'h0, "ack_tmo", w);
    @(negedge clk);
    checks++;
    if (if_ready !== 1'b1 || if_err !== 1'b0) begin
      errors++;
      $display("FAIL ack_tmo_ready: if_ready=%0b if_err=%0b, required 1 0", if_ready, if_err);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset_mid_transaction();
    int w;
    int n;
    int rdy;
    @(posedge clk);
    #1 d_we = 1'b0; d_addr = 32'h40; d_req = 1'b1;
    n = 0;
    @(negedge clk);
    while (!mem_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1 reset = 1'b0; d_req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (mem_valid !== 1'b0 || if_ready !== 1'b0 || d_ready !== 1'b0) begin
      errors++;
      $display("FAIL rst_abort: mem_valid=%0b if_ready=%0b d_ready=%0b, required 0 0 0",
               mem_valid, if_ready, d_ready);
    end
    @(posedge clk);
    #1 reset = 1'b1;
    rdy = 0;
    repeat (4) begin
      @(negedge clk);
      if (if_ready || d_ready || mem_valid) rdy++;
    end
    checks++;
    if (rdy != 0) begin
      errors++;
      $display("FAIL rst_quiet: %0d active cycles after release, required 0", rdy);
    end
    @(posedge clk);
    #1 d_addr = 32'h44; d_req = 1'b1;
    push_exp(1'b1, 1'b1, 32'hA5A5A5A5, 1'b0);
    mem_serve(2, 32'hA5A5A5A5, 32'h44, 1'b0, 32'h0, "rst_fresh", w);
    @(negedge clk);
    checks++;
    if (d_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_fresh_ready: d_ready=%0b, required 1", d_ready);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_robustness();
    int w;
    int n;
    int act;
    @(posedge clk);
    #1 mem_ack = 1'b1; mem_rdata = 32'h5555;
    @(posedge clk);
    #1 mem_ack = 1'b0;
    act = 0;
    repeat (3) begin
      @(negedge clk);
      if (if_ready || d_ready || mem_valid) act++;
    end
    checks++;
    if (act != 0) begin
      errors++;
      $display("FAIL spurious_ack: %0d active cycles, required 0", act);
    end
    @(posedge clk);
    #1 d_we = 1'b0; d_addr = 32'h80; d_req = 1'b1;
    n = 0;
    @(negedge clk);
    while (!mem_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    d_req = 1'b0; d_addr = 32'hBAD0;
    push_exp(1'b1, 1'b1, 32'h0BADF00D, 1'b0);
    mem_serve(2, 32'h0BADF00D, 32'h80, 1'b0, 32'h0, "drop", w);
    @(negedge clk);
    checks++;
    if (d_ready !== 1'b1) begin
      errors++;
      $display("FAIL drop_ready: d_ready=%0b, required 1", d_ready);
    end
    act = 0;
    repeat (5) begin
      @(negedge clk);
      if (mem_valid || d_ready || if_ready) act++;
    end
    checks++;
    if (act != 0) begin
      errors++;
      $display("FAIL drop_no_repeat: %0d active cycles after completion, required 0", act);
    end
  endtask

  initial begin
    test_reset();
    test_single_fetch();
    test_tie_round_robin();
    test_timeout();
    test_ack_on_timeout();
    test_reset_mid_transaction();
    test_robustness();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d responses outstanding, required 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
